// File: rtl/bus_arbiter.sv
// Two-master (IFU read, LSU read/write) to two-slave (SoC, read-only CLINT) arbiter.
// Single-beat transfers, round-robin on ties, one owner at a time.
`timescale 1ns/1ps
module bus_arbiter #(
   parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
   parameter logic [31:0] CLINT_SIZE = 32'h0001_0000
) (
   input  logic        clk,
   input  logic        resetn,
   // IFU read port
   input  logic        m0_arvalid,
   output logic        m0_arready,
   input  logic [31:0] m0_araddr,
   output logic        m0_rvalid,
   input  logic        m0_rready,
   output logic [31:0] m0_rdata,
   output logic [1:0]  m0_rresp,
   // LSU read port
   input  logic        m1_arvalid,
   output logic        m1_arready,
   input  logic [31:0] m1_araddr,
   output logic        m1_rvalid,
   input  logic        m1_rready,
   output logic [31:0] m1_rdata,
   output logic [1:0]  m1_rresp,
   // LSU write port
   input  logic        m1_awvalid,
   output logic        m1_awready,
   input  logic [31:0] m1_awaddr,
   input  logic        m1_wvalid,
   output logic        m1_wready,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_bvalid,
   input  logic        m1_bready,
   output logic [1:0]  m1_bresp,
   // SoC slave port
   output logic        s_arvalid,
   input  logic        s_arready,
   output logic [31:0] s_araddr,
   input  logic        s_rvalid,
   output logic        s_rready,
   input  logic [31:0] s_rdata,
   input  logic [1:0]  s_rresp,
   output logic        s_awvalid,
   input  logic        s_awready,
   output logic [31:0] s_awaddr,
   output logic        s_wvalid,
   input  logic        s_wready,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic        s_bvalid,
   output logic        s_bready,
   input  logic [1:0]  s_bresp,
   // CLINT slave port (read-only)
   output logic        c_arvalid,
   input  logic        c_arready,
   output logic [31:0] c_araddr,
   input  logic        c_rvalid,
   output logic        c_rready,
   input  logic [31:0] c_rdata,
   input  logic [1:0]  c_rresp,
   output logic [1:0]  grant
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned RW = 2;
   localparam logic        OWN_IFU = 1'b0;
   localparam logic        OWN_LSU = 1'b1;
   localparam logic [RW-1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {IDLE, RD_M0, RD_M1, WR_M1, WR_ERR} state_e;

   state_e        state_q, state_d;
   logic          last_q, last_d;
   logic          tgt_q, tgt_d;         // 1 = CLINT, 0 = SoC
   logic          ar_done_q, ar_done_d;
   logic          aw_done_q, aw_done_d;
   logic          w_done_q, w_done_d;
   logic          berr_q, berr_d;
   logic [1:0]    grant_q, grant_d;

   logic          sel_arvalid, sel_rready, sel_arready, sel_rvalid;
   logic [AW-1:0] sel_araddr;
   logic [DW-1:0] sel_rdata;
   logic [RW-1:0] sel_rresp;

   // Window check done in AW+1 bits so BASE+SIZE cannot wrap.
   function automatic logic is_clint(input logic [AW-1:0] a);
      logic [AW:0] lim;
      lim = {1'b0, CLINT_BASE} + {1'b0, CLINT_SIZE};
      return (a >= CLINT_BASE) && ({1'b0, a} < lim);
   endfunction

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= IDLE;
         last_q    <= OWN_IFU;
         tgt_q     <= 1'b0;
         ar_done_q <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         berr_q    <= 1'b0;
         grant_q   <= 2'b00;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         tgt_q     <= tgt_d;
         ar_done_q <= ar_done_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         berr_q    <= berr_d;
         grant_q   <= grant_d;
      end
   end

   assign grant = grant_q;

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      tgt_d     = tgt_q;
      ar_done_d = ar_done_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      berr_d    = berr_q;
      sel_arvalid = 1'b0;
      sel_araddr  = '0;
      sel_rready  = 1'b0;
      sel_arready = 1'b0;
      sel_rvalid  = 1'b0;
      sel_rdata   = '0;
      sel_rresp   = '0;
      m0_arready = 1'b0; m0_rvalid = 1'b0; m0_rdata = '0; m0_rresp = '0;
      m1_arready = 1'b0; m1_rvalid = 1'b0; m1_rdata = '0; m1_rresp = '0;
      m1_awready = 1'b0; m1_wready = 1'b0; m1_bvalid = 1'b0; m1_bresp = '0;
      s_arvalid = 1'b0; s_araddr = '0; s_rready = 1'b0;
      s_awvalid = 1'b0; s_awaddr = '0; s_wvalid = 1'b0; s_wdata = '0; s_wstrb = '0;
      s_bready  = 1'b0;
      c_arvalid = 1'b0; c_araddr = '0; c_rready = 1'b0;

      // Outputs stay quiet while reset is held, even before the state register clears.
      if (resetn) begin
         unique case (state_q)
            IDLE: begin
               ar_done_d = 1'b0;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               berr_d    = 1'b0;
               if ((m1_arvalid || m1_awvalid) && (!m0_arvalid || last_q == OWN_IFU)) begin
                  last_d = OWN_LSU;
                  if (m1_arvalid) begin
                     state_d = RD_M1;
                     tgt_d   = is_clint(m1_araddr);
                  end else if (is_clint(m1_awaddr)) begin
                     state_d = WR_ERR;
                     tgt_d   = 1'b1;
                  end else begin
                     state_d = WR_M1;
                     tgt_d   = 1'b0;
                  end
               end else if (m0_arvalid) begin
                  last_d  = OWN_IFU;
                  state_d = RD_M0;
                  tgt_d   = is_clint(m0_araddr);
               end
            end
            RD_M0, RD_M1: begin
               if (state_q == RD_M0) begin
                  sel_arvalid = m0_arvalid & ~ar_done_q;
                  sel_araddr  = m0_araddr;
                  sel_rready  = m0_rready;
               end else begin
                  sel_arvalid = m1_arvalid & ~ar_done_q;
                  sel_araddr  = m1_araddr;
                  sel_rready  = m1_rready;
               end
               if (tgt_q) begin
                  c_arvalid   = sel_arvalid;
                  c_araddr    = sel_araddr;
                  c_rready    = sel_rready;
                  sel_arready = c_arready & ~ar_done_q;
                  sel_rvalid  = c_rvalid;
                  sel_rdata   = c_rdata;
                  sel_rresp   = c_rresp;
               end else begin
                  s_arvalid   = sel_arvalid;
                  s_araddr    = sel_araddr;
                  s_rready    = sel_rready;
                  sel_arready = s_arready & ~ar_done_q;
                  sel_rvalid  = s_rvalid;
                  sel_rdata   = s_rdata;
                  sel_rresp   = s_rresp;
               end
               if (state_q == RD_M0) begin
                  m0_arready = sel_arready;
                  m0_rvalid  = sel_rvalid;
                  m0_rdata   = sel_rvalid ? sel_rdata : '0;
                  m0_rresp   = sel_rvalid ? sel_rresp : '0;
               end else begin
                  m1_arready = sel_arready;
                  m1_rvalid  = sel_rvalid;
                  m1_rdata   = sel_rvalid ? sel_rdata : '0;
                  m1_rresp   = sel_rvalid ? sel_rresp : '0;
               end
               if (sel_arvalid && sel_arready) ar_done_d = 1'b1;
               if (sel_rvalid && sel_rready)   state_d   = IDLE;
            end
            WR_M1: begin
               s_awvalid  = m1_awvalid & ~aw_done_q;
               s_awaddr   = m1_awaddr;
               m1_awready = s_awready & ~aw_done_q;
               s_wvalid   = m1_wvalid & ~w_done_q;
               s_wdata    = m1_wdata;
               s_wstrb    = m1_wstrb;
               m1_wready  = s_wready & ~w_done_q;
               s_bready   = m1_bready;
               m1_bvalid  = s_bvalid;
               m1_bresp   = s_bvalid ? s_bresp : '0;
               if (m1_awvalid && s_awready && !aw_done_q) aw_done_d = 1'b1;
               if (m1_wvalid && s_wready && !w_done_q)    w_done_d  = 1'b1;
               if (s_bvalid && m1_bready)                 state_d   = IDLE;
            end
            WR_ERR: begin
               // Writes into the CLINT window are absorbed here and answered with DECERR.
               m1_awready = ~aw_done_q;
               m1_wready  = ~w_done_q;
               m1_bvalid  = berr_q;
               m1_bresp   = berr_q ? RESP_DECERR : '0;
               if (m1_awvalid && !aw_done_q) aw_done_d = 1'b1;
               if (m1_wvalid && !w_done_q)   w_done_d  = 1'b1;
               if (berr_q) begin
                  if (m1_bready) state_d = IDLE;
               end else begin
                  berr_d = aw_done_d & w_done_d;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      unique case (state_d)
         RD_M0:                 grant_d = 2'b01;
         RD_M1, WR_M1, WR_ERR:  grant_d = 2'b10;
         default:               grant_d = 2'b00;
      endcase
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: routing, round-robin ties, CLINT write error,
// split aw/w ordering and mid-transfer reset.
`timescale 1ns/1ps
module tb_bus_arbiter;

   logic        clk, resetn;
   logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
   logic [31:0] m0_araddr, m0_rdata;
   logic [1:0]  m0_rresp;
   logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
   logic [31:0] m1_araddr, m1_rdata;
   logic [1:0]  m1_rresp;
   logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
   logic [31:0] m1_awaddr, m1_wdata;
   logic [3:0]  m1_wstrb;
   logic [1:0]  m1_bresp;
   logic        s_arvalid, s_arready, s_rvalid, s_rready;
   logic [31:0] s_araddr, s_rdata;
   logic [1:0]  s_rresp;
   logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic [31:0] s_awaddr, s_wdata;
   logic [3:0]  s_wstrb;
   logic [1:0]  s_bresp;
   logic        c_arvalid, c_arready, c_rvalid, c_rready;
   logic [31:0] c_araddr, c_rdata;
   logic [1:0]  c_rresp;
   logic [1:0]  grant;

   int n_checks = 0;
   int n_errors = 0;

   bus_arbiter dut (
      .clk(clk), .resetn(resetn),
      .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
      .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
      .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
      .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
      .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr),
      .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
      .c_arvalid(c_arvalid), .c_arready(c_arready), .c_araddr(c_araddr),
      .c_rvalid(c_rvalid), .c_rready(c_rready), .c_rdata(c_rdata), .c_rresp(c_rresp),
      .grant(grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called just after the grant edge: ar handshakes on the next edge, then data returns.
   // The non-target slave also asserts rvalid with different data, which must not leak through.
   task automatic read_data(input logic lsu, input logic clint, input logic [31:0] data, input string tag);
      step();
      if (lsu) m1_arvalid = 1'b0; else m0_arvalid = 1'b0;
      c_rvalid = 1'b1; s_rvalid = 1'b1;
      c_rresp = 2'b01; s_rresp = 2'b01;
      c_rdata = clint ? data : ~data;
      s_rdata = clint ? ~data : data;
      #1;
      check(tag, lsu ? m1_rdata : m0_rdata, data);
      check(tag, 32'(lsu ? m1_rresp : m0_rresp), 32'h1);
      check(tag, 32'(lsu ? m0_rvalid : m1_rvalid), 32'h0);
      step();
      c_rvalid = 1'b0; s_rvalid = 1'b0;
      #1;
      check(tag, 32'(grant), 32'h0);
   endtask

   task automatic route(input logic [31:0] addr, input logic exp_clint, input string tag);
      m1_arvalid = 1'b1;
      m1_araddr  = addr;
      step();
      check(tag, 32'(c_arvalid), 32'(exp_clint));
      check(tag, 32'(s_arvalid), 32'(!exp_clint));
      check(tag, exp_clint ? c_araddr : s_araddr, addr);
      read_data(1'b1, exp_clint, addr ^ 32'h5A5A_0000, tag);
   endtask

   initial begin
      resetn = 1'b0;
      m0_arvalid = 0; m0_araddr = '0; m0_rready = 1;
      m1_arvalid = 0; m1_araddr = '0; m1_rready = 1;
      m1_awvalid = 0; m1_awaddr = '0; m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_bready = 0;
      s_arready = 1; s_rvalid = 0; s_rdata = '0; s_rresp = '0;
      s_awready = 1; s_wready = 1; s_bvalid = 0; s_bresp = '0;
      c_arready = 1; c_rvalid = 0; c_rdata = '0; c_rresp = '0;

      // Reset: requests present but everything held quiet
      m0_arvalid = 1; m1_awvalid = 1; m1_wvalid = 1;
      repeat (2) step();
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_s_arvalid", 32'(s_arvalid), 32'h0);
      check("rst_m0_arready", 32'(m0_arready), 32'h0);
      check("rst_m1_awready", 32'(m1_awready), 32'h0);
      check("rst_m1_wready", 32'(m1_wready), 32'h0);
      check("rst_m1_bvalid", 32'(m1_bvalid), 32'h0);
      m0_arvalid = 0; m1_awvalid = 0; m1_wvalid = 0;
      resetn = 1;
      step();

      // IFU alone reads SoC
      m0_arvalid = 1; m0_araddr = 32'h3000_0000;
      #1;
      check("ifu_idle_grant", 32'(grant), 32'h0);
      check("ifu_idle_s_arvalid", 32'(s_arvalid), 32'h0);
      step();
      check("ifu_grant", 32'(grant), 32'h1);
      check("ifu_s_arvalid", 32'(s_arvalid), 32'h1);
      check("ifu_s_araddr", s_araddr, 32'h3000_0000);
      check("ifu_m0_arready", 32'(m0_arready), 32'h1);
      check("ifu_c_arvalid", 32'(c_arvalid), 32'h0);
      read_data(1'b0, 1'b0, 32'hDEAD_BEEF, "ifu_rdata");

      // Fresh reset so last-owner is back to IFU
      resetn = 0;
      step();
      resetn = 1;

      // Tie 1 after reset -> LSU, then IFU after an idle cycle
      m0_arvalid = 1; m0_araddr = 32'h3000_0000;
      m1_arvalid = 1; m1_araddr = 32'h3000_0100;
      step();
      check("tie1_grant", 32'(grant), 32'h2);
      check("tie1_s_araddr", s_araddr, 32'h3000_0100);
      check("tie1_m0_arready", 32'(m0_arready), 32'h0);
      read_data(1'b1, 1'b0, 32'h1111_1111, "tie1_lsu");
      step();
      check("tie1_ifu_grant", 32'(grant), 32'h1);
      read_data(1'b0, 1'b0, 32'h2222_2222, "tie1_ifu");

      // Tie 2: IFU served last -> LSU
      m0_arvalid = 1; m1_arvalid = 1;
      step();
      check("tie2_grant", 32'(grant), 32'h2);
      read_data(1'b1, 1'b0, 32'h3333_3333, "tie2_lsu");
      step();
      check("tie2_ifu_grant", 32'(grant), 32'h1);
      read_data(1'b0, 1'b0, 32'h4444_4444, "tie2_ifu");

      // CLINT window routing including both edges
      route(32'h0200_BFF8, 1'b1, "rt_mtime");
      route(32'h0200_0000, 1'b1, "rt_base");
      route(32'h0200_FFFF, 1'b1, "rt_top");
      route(32'h0201_0000, 1'b0, "rt_above");
      route(32'h01FF_FFFF, 1'b0, "rt_below");

      // Tie 3: LSU served last -> IFU
      m0_arvalid = 1; m0_araddr = 32'h3000_0008;
      m1_arvalid = 1; m1_araddr = 32'h3000_000C;
      step();
      check("tie3_grant", 32'(grant), 32'h1);
      read_data(1'b0, 1'b0, 32'h5555_5555, "tie3_ifu");
      step();
      check("tie3_lsu_grant", 32'(grant), 32'h2);
      read_data(1'b1, 1'b0, 32'h6666_6666, "tie3_lsu");

      // Write into CLINT -> local DECERR, no slave traffic
      m1_awvalid = 1; m1_awaddr = 32'h0200_0000;
      m1_wvalid = 1; m1_wdata = 32'hCAFE_F00D; m1_wstrb = 4'hF; m1_bready = 0;
      step();
      check("werr_grant", 32'(grant), 32'h2);
      check("werr_s_awvalid", 32'(s_awvalid), 32'h0);
      check("werr_s_wvalid", 32'(s_wvalid), 32'h0);
      check("werr_awready", 32'(m1_awready), 32'h1);
      check("werr_wready", 32'(m1_wready), 32'h1);
      check("werr_bvalid_early", 32'(m1_bvalid), 32'h0);
      step();
      m1_awvalid = 0; m1_wvalid = 0;
      #1;
      check("werr_bvalid", 32'(m1_bvalid), 32'h1);
      check("werr_bresp", 32'(m1_bresp), 32'h3);
      check("werr_awready_done", 32'(m1_awready), 32'h0);
      step();
      check("werr_bvalid_hold", 32'(m1_bvalid), 32'h1);
      check("werr_grant_hold", 32'(grant), 32'h2);
      m1_bready = 1;
      step();
      check("werr_end_grant", 32'(grant), 32'h0);
      check("werr_end_bvalid", 32'(m1_bvalid), 32'h0);
      m1_bready = 0;

      // SoC write, slave takes w before aw; IFU waits throughout
      m1_awvalid = 1; m1_awaddr = 32'h3000_0040;
      m1_wvalid = 1; m1_wdata = 32'h5555_AAAA; m1_wstrb = 4'b0011;
      s_awready = 0; s_wready = 1;
      step();
      m0_arvalid = 1; m0_araddr = 32'h3000_0080;
      #1;
      check("wr_grant", 32'(grant), 32'h2);
      check("wr_s_wvalid", 32'(s_wvalid), 32'h1);
      check("wr_s_wdata", s_wdata, 32'h5555_AAAA);
      check("wr_s_wstrb", 32'(s_wstrb), 32'h3);
      check("wr_s_awvalid", 32'(s_awvalid), 32'h1);
      check("wr_awready_wait", 32'(m1_awready), 32'h0);
      step();
      m1_wvalid = 0; s_awready = 1;
      #1;
      check("wr_wready_done", 32'(m1_wready), 32'h0);
      check("wr_awready", 32'(m1_awready), 32'h1);
      check("wr_s_awaddr", s_awaddr, 32'h3000_0040);
      step();
      m1_awvalid = 0; s_bvalid = 1; s_bresp = 2'b00; m1_bready = 1;
      #1;
      check("wr_bvalid", 32'(m1_bvalid), 32'h1);
      check("wr_bresp", 32'(m1_bresp), 32'h0);
      check("wr_s_bready", 32'(s_bready), 32'h1);
      check("wr_grant_b", 32'(grant), 32'h2);
      step();
      s_bvalid = 0; m1_bready = 0;
      #1;
      check("wr_end_grant", 32'(grant), 32'h0);
      check("wr_end_bvalid", 32'(m1_bvalid), 32'h0);
      step();
      check("wr_ifu_grant", 32'(grant), 32'h1);
      read_data(1'b0, 1'b0, 32'h7777_7777, "wr_ifu");

      // Reset during RD_M1 with response pending
      m1_arvalid = 1; m1_araddr = 32'h3000_0200;
      step();
      check("mrst_grant", 32'(grant), 32'h2);
      step();
      m1_arvalid = 0; resetn = 0;
      #1;
      check("mrst_s_arvalid", 32'(s_arvalid), 32'h0);
      check("mrst_s_rready", 32'(s_rready), 32'h0);
      step();
      check("mrst_grant_rst", 32'(grant), 32'h0);
      s_rvalid = 1; s_rdata = 32'hBAD0_BAD0;
      #1;
      check("mrst_rvalid_rst", 32'(m1_rvalid), 32'h0);
      check("mrst_c_rready", 32'(c_rready), 32'h0);
      resetn = 1;
      step();
      check("mrst_rvalid_idle", 32'(m1_rvalid), 32'h0);
      check("mrst_rdata_idle", m1_rdata, 32'h0);
      check("mrst_grant_idle", 32'(grant), 32'h0);
      s_rvalid = 0;
      m0_arvalid = 1; m0_araddr = 32'h3000_0300;
      step();
      check("mrst_next_grant", 32'(grant), 32'h1);
      read_data(1'b0, 1'b0, 32'h8888_8888, "mrst_next");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter CLINT_BASE, default 32'h0200_0000, meaning the base address of the CLINT window.
REQ-002 SHALL have parameter CLINT_SIZE, default 32'h0001_0000, meaning the CLINT window size in bytes.
REQ-003 SHALL have clk  input  1  clock; all logic on the rising edge.
REQ-004 SHALL have resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have IFU read port m0_arvalid in 1, m0_arready out 1, m0_araddr in 32, m0_rvalid out 1, m0_rready in 1, m0_rdata out 32, m0_rresp out 2.
REQ-006 SHALL have LSU read port m1_arvalid in 1, m1_arready out 1, m1_araddr in 32, m1_rvalid out 1, m1_rready in 1, m1_rdata out 32, m1_rresp out 2.
REQ-007 SHALL have LSU write port m1_awvalid in 1, m1_awready out 1, m1_awaddr in 32, m1_wvalid in 1, m1_wready out 1, m1_wdata in 32, m1_wstrb in 4, m1_bvalid out 1, m1_bready in 1, m1_bresp out 2.
REQ-008 SHALL have SoC slave port s_ar*/s_r*/s_aw*/s_w*/s_b* with the same fields and widths as REQ-006 and REQ-007, directions mirrored.
REQ-009 SHALL have CLINT read-only slave port c_ar*/c_r* with the same fields and widths as REQ-006, directions mirrored.
REQ-010 SHALL have grant  output  2  one-hot owner: 2'b01 = IFU, 2'b10 = LSU, 2'b00 = idle.

Function
REQ-011 SHALL implement FSM states IDLE, RD_M0, RD_M1, WR_M1, WR_ERR.
REQ-012 SHALL sample requests only in IDLE: m0_arvalid for IFU; m1_arvalid or m1_awvalid for LSU.
REQ-013 SHALL resolve a simultaneous IFU and LSU request in favour of the master not granted last (round-robin); the last-owner register resets to IFU, so the first tie goes to LSU.
REQ-014 SHALL, within LSU, take read before write when m1_arvalid and m1_awvalid are both high.
REQ-015 SHALL register the grant: request seen in IDLE at edge N leaves the FSM in the owner state from cycle N+1; grant is a registered output.
REQ-016 SHALL latch the target at grant: CLINT when CLINT_BASE <= addr < CLINT_BASE+CLINT_SIZE (32-bit unsigned compare, no wrap), otherwise SoC.
REQ-017 SHALL, in read states, combinationally forward the owner's ar and r channels to the latched target only; the other slave sees arvalid=0 and rready=0.
REQ-018 SHALL return RD_* to IDLE on the edge where the owner's rvalid and rready are both high; single-beat transfers only.
REQ-019 SHALL, in WR_M1 with a SoC target, forward aw and w independently (either order or the same cycle) and return to IDLE on the b handshake.
REQ-020 SHALL enter WR_ERR instead of WR_M1 for a write to CLINT, with no slave traffic.
REQ-021 SHALL, in WR_ERR, accept aw and w locally (awready=wready=1 until each is handshaken), then drive m1_bvalid=1 and m1_bresp=2'b11 from the cycle after both are accepted, holding until m1_bready.
REQ-022 SHALL hold a non-owner's arready, rvalid, awready, wready and bvalid at 0; slave responses arriving in IDLE or for the non-target slave are not forwarded.
REQ-023 SHALL return to IDLE for one cycle between ownerships (grant=00), so back-to-back grants are separated by at least one idle cycle.
REQ-024 SHALL pass rresp from the slave unchanged and drive rdata/rresp as 0 whenever rvalid is 0.

Reset
REQ-025 SHALL, while resetn=0, set the FSM to IDLE, grant=00, last-owner=IFU, and hold every valid and ready output at 0.
REQ-026 SHALL, on reset asserted mid-transfer, abandon the transfer without completing or forwarding the pending response; the next transfer starts from IDLE.

Verification
REQ-027 IFU alone reads 0x3000_0000 -> grant=01 one cycle later, s_arvalid=1, s_araddr=0x3000_0000; s_rdata=0xDEADBEEF returned on m0_rdata; IDLE after the r handshake.
REQ-028 IFU read and LSU read in the same cycle after reset -> LSU is granted first, IFU next; a second tie is granted to the master not served last.
REQ-029 LSU reads 0x0200_BFF8 -> c_arvalid=1, s_arvalid=0; c_rdata is returned on m1_rdata.
REQ-030 LSU writes to 0x0200_0000 -> no slave valid; m1_bresp=2'b11 and bvalid held until bready.
REQ-031 LSU write to SoC with w before aw -> one b handshake, grant returns to 00; an IFU request pending throughout is granted next.
REQ-032 resetn=0 during RD_M1 with the slave response pending -> grant=00 and all valids 0 on the next edge; the late s_rvalid is not forwarded.
